// File: rtl/calc_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_sequencer_if
// Purpose : bundles the operand-entry handshake, the result handshake and the
//           status outputs of calc_sequencer.
// Signals :
//   clear        producer -> block  synchronous abort to operand-A entry
//   in_valid     producer -> block  operand on sw is valid
//   sw[3:0]      producer -> block  operand value
//   op_sub       producer -> block  1 = subtract, 0 = add (taken with B)
//   in_ready     block -> producer  operand accepted this cycle if in_valid
//   result_ack   consumer -> block  consumer has taken the result
//   result_valid block -> consumer  result/neg/carry are valid
//   result[3:0]  block -> consumer  sum, or difference magnitude
//   neg          block -> consumer  subtract with B > A
//   carry        block -> consumer  add overflowed 4 bits
//   state_o[1:0] block -> observer  current FSM state
//   op_count[7:0]block -> observer  completed (acknowledged) operations
// Modports: master = environment side, slave = calc_sequencer side.
// ---------------------------------------------------------------------------
interface calc_sequencer_if;
  logic       clear;
  logic       in_valid;
  logic [3:0] sw;
  logic       op_sub;
  logic       in_ready;
  logic       result_ack;
  logic       result_valid;
  logic [3:0] result;
  logic       neg;
  logic       carry;
  logic [1:0] state_o;
  logic [7:0] op_count;

  modport master (
    output clear, in_valid, sw, op_sub, result_ack,
    input  in_ready, result_valid, result, neg, carry, state_o, op_count
  );

  modport slave (
    input  clear, in_valid, sw, op_sub, result_ack,
    output in_ready, result_valid, result, neg, carry, state_o, op_count
  );
endinterface

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Purpose : two-operand 4-bit add/subtract sequencer. Operand A then operand B
//           are taken over a valid/ready handshake, the result is computed in
//           one EXEC cycle and presented in SHOW until acknowledged.
// Ports   :
//   clk   rising-edge clock
//   rst   synchronous active-high reset, highest priority
//   bus   calc_sequencer_if.slave (operand/result handshakes and status)
// Handshakes:
//   Operand transfer happens on a rising edge where in_valid & in_ready;
//   in_ready is high only in LOAD_A / LOAD_B. The result is offered while
//   result_valid (SHOW) and is consumed on an edge where result_ack is high.
// Option  : define CALC_SEQ_TIMEOUT_EN to abandon SHOW after 256 cycles
//           without result_ack (no op_count increment on timeout).
// ---------------------------------------------------------------------------
module calc_sequencer (
  input  logic                clk,
  input  logic                rst,
  calc_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_op_sub;
  logic [3:0] r_result;
  logic       r_neg;
  logic       r_carry;
  logic [7:0] r_op_count;
`ifdef CALC_SEQ_TIMEOUT_EN
  logic [7:0] r_tmo;
`endif

  // Datapath evaluated from the operand registers; captured in EXEC.
  logic [4:0] w_sum;
  logic       w_b_gt_a;
  logic [3:0] w_diff;
  logic [3:0] w_res;
  logic       w_neg;
  logic       w_carry;

  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_b_gt_a = (r_b > r_a);
  assign w_diff   = w_b_gt_a ? (r_b - r_a) : (r_a - r_b);
  assign w_res    = r_op_sub ? w_diff : w_sum[3:0];
  assign w_neg    = r_op_sub & w_b_gt_a;
  assign w_carry  = ~r_op_sub & w_sum[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD_A;
      r_a        <= 4'h0;
      r_b        <= 4'h0;
      r_op_sub   <= 1'b0;
      r_result   <= 4'h0;
      r_neg      <= 1'b0;
      r_carry    <= 1'b0;
      r_op_count <= 8'h00;
`ifdef CALC_SEQ_TIMEOUT_EN
      r_tmo      <= 8'h00;
`endif
    end else if (bus.clear) begin
      // Abort wins over any transfer or acknowledge in the same cycle.
      r_state  <= LOAD_A;
      r_a      <= 4'h0;
      r_b      <= 4'h0;
      r_result <= 4'h0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (bus.in_valid) begin
            r_a     <= bus.sw;
            r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            r_b      <= bus.sw;
            r_op_sub <= bus.op_sub;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_result <= w_res;
          r_neg    <= w_neg;
          r_carry  <= w_carry;
          r_state  <= SHOW;
`ifdef CALC_SEQ_TIMEOUT_EN
          r_tmo    <= 8'h00;
`endif
        end
        SHOW: begin
          if (bus.result_ack) begin
            r_op_count <= r_op_count + 8'd1;
            r_state    <= LOAD_A;
          end
`ifdef CALC_SEQ_TIMEOUT_EN
          // Counter reads 255 on the 256th SHOW cycle; leave without counting.
          else if (r_tmo == 8'hFF) begin
            r_state <= LOAD_A;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
`endif
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  // All outputs are decoded directly from registers.
  assign bus.in_ready     = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign bus.result_valid = (r_state == SHOW);
  assign bus.result       = r_result;
  assign bus.neg          = r_neg;
  assign bus.carry        = r_carry;
  assign bus.state_o      = r_state;
  assign bus.op_count     = r_op_count;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  logic clk;
  logic rst;
  calc_sequencer_if bus ();

  calc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_cnt;
  logic [5:0] exp_q[$];

  // observation vector: state, in_ready, result_valid, result, neg, carry
  logic [9:0] obs;
  assign obs = {bus.state_o, bus.in_ready, bus.result_valid, bus.result, bus.neg, bus.carry};

  // ---------------- driver tasks ----------------
  task automatic transfer(input logic [3:0] v, input logic sub);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sw       = v;
    bus.op_sub   = sub;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // A then B, then one more edge: returns #1 after entering SHOW.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sub);
    transfer(a, 1'b0);
    transfer(b, sub);
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.result_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== {2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_obs: got %h expected %h", obs, {2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    end
    checks++;
    if (bus.op_count !== 8'd0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", bus.op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic test_add();
    transfer(4'd5, 1'b0);
    transfer(4'd3, 1'b0);
    checks++;
    if (obs[9:6] !== {2'b10, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_exec: got %h expected %h", obs[9:6], 4'b1000);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_5_3: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_hold: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0});
    end
    do_ack();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({obs[9:6], bus.op_count} !== {4'b0010, exp_cnt}) begin
      failures++; $display("FAIL add_ack: got %h expected %h", {obs[9:6], bus.op_count}, {4'b0010, exp_cnt});
    end
  endtask

  task automatic test_add_carry();
    run_op(4'd9, 4'd9, 1'b0);
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1}) begin
      failures++; $display("FAIL add_9_9: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1});
    end
    do_ack();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({obs[9:6], bus.op_count} !== {4'b0010, exp_cnt}) begin
      failures++; $display("FAIL carry_ack: got %h expected %h", {obs[9:6], bus.op_count}, {4'b0010, exp_cnt});
    end
  endtask

  task automatic test_sub();
    run_op(4'd3, 4'd7, 1'b1);
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_3_7: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0});
    end
    do_ack(); exp_cnt = exp_cnt + 8'd1;
    run_op(4'd7, 4'd7, 1'b1);
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub_7_7: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
    end
    do_ack(); exp_cnt = exp_cnt + 8'd1;
    run_op(4'd12, 4'd5, 1'b1);
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub_12_5: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0});
    end
    do_ack(); exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (bus.op_count !== exp_cnt) begin
      failures++; $display("FAIL sub_count: got %0d expected %0d", bus.op_count, exp_cnt);
    end
  endtask

  task automatic test_ignore();
    transfer(4'd2, 1'b0);
    transfer(4'd4, 1'b0);
    // EXEC now; offer an operand that must be ignored through EXEC and SHOW
    @(negedge clk);
    bus.in_valid = 1'b1; bus.sw = 4'hF; bus.op_sub = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ignore_exec: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ignore_show: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0});
    end
    bus.in_valid = 1'b0;
    do_ack(); exp_cnt = exp_cnt + 8'd1;
    // ack in LOAD_A must be ignored
    do_ack();
    checks++;
    if ({obs[9:6], bus.op_count} !== {4'b0010, exp_cnt}) begin
      failures++; $display("FAIL ignore_ack: got %h expected %h", {obs[9:6], bus.op_count}, {4'b0010, exp_cnt});
    end
  endtask

  task automatic test_clear();
    transfer(4'd6, 1'b0);
    checks++;
    if (obs[9:6] !== 4'b0110) begin
      failures++; $display("FAIL clear_loadb_state: got %h expected %h", obs[9:6], 4'b0110);
    end
    // clear together with a transfer in LOAD_B: transfer discarded
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.sw = 4'd2;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if ({obs, bus.op_count} !== {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL clear_loadb: got %h expected %h", {obs, bus.op_count}, {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, exp_cnt});
    end
    // clear in EXEC
    transfer(4'd1, 1'b0);
    transfer(4'd1, 1'b0);
    @(negedge clk); bus.clear = 1'b1;
    @(posedge clk); #1; bus.clear = 1'b0;
    checks++;
    if (obs !== {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL clear_exec: got %h expected %h", obs, {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    end
    // clear + ack in SHOW: clear wins, no count
    run_op(4'd15, 4'd4, 1'b0);
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1}) begin
      failures++; $display("FAIL add_15_4: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1});
    end
    @(negedge clk); bus.clear = 1'b1; bus.result_ack = 1'b1;
    @(posedge clk); #1; bus.clear = 1'b0; bus.result_ack = 1'b0;
    checks++;
    if ({obs, bus.op_count} !== {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL clear_ack_show: got %h expected %h", {obs, bus.op_count}, {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, exp_cnt});
    end
  endtask

  task automatic test_reset_mid();
    run_op(4'd8, 4'd8, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.result_ack = 1'b1; bus.in_valid = 1'b1; bus.clear = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.result_ack = 1'b0; bus.in_valid = 1'b0; bus.clear = 1'b0;
    exp_cnt = 8'd0;
    checks++;
    if ({obs, bus.op_count} !== {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, exp_cnt}) begin
      failures++; $display("FAIL reset_show: got %h expected %h", {obs, bus.op_count}, {2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, exp_cnt});
    end
  endtask

  task automatic test_wrap();
    logic [3:0] a, b;
    logic       sub;
    logic [4:0] s;
    logic [5:0] exp;
    for (int i = 0; i < 256; i++) begin
      a   = 4'(i);
      b   = 4'(i >> 4);
      sub = i[4] ^ i[0];
      s   = {1'b0, a} + {1'b0, b};
      if (sub) exp_q.push_back({(b > a) ? b - a : a - b, b > a, 1'b0});
      else     exp_q.push_back({s[3:0], 1'b0, s[4]});
      run_op(a, b, sub);
      exp = exp_q.pop_front();
      checks++;
      if (obs[5:0] !== exp) begin
        failures++; $display("FAIL wrap_op%0d a=%0d b=%0d sub=%0b: got %h expected %h", i, a, b, sub, obs[5:0], exp);
      end
      do_ack();
      exp_cnt = exp_cnt + 8'd1;
      if (i == 254 || i == 255) begin
        checks++;
        if (bus.op_count !== exp_cnt) begin
          failures++; $display("FAIL wrap_count%0d: got %0d expected %0d", i, bus.op_count, exp_cnt);
        end
      end
    end
  endtask

`ifdef CALC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_op(4'd1, 4'd2, 1'b0);   // first SHOW cycle
    repeat (255) @(posedge clk);
    #1;
    checks++;
    if (obs[9:6] !== 4'b1101) begin
      failures++; $display("FAIL tmo_still_show: got %h expected %h", obs[9:6], 4'b1101);
    end
    @(posedge clk); #1;
    checks++;
    if ({obs[9:6], bus.op_count} !== {4'b0010, exp_cnt}) begin
      failures++; $display("FAIL tmo_expire: got %h expected %h", {obs[9:6], bus.op_count}, {4'b0010, exp_cnt});
    end
    run_op(4'd1, 4'd2, 1'b0);
    repeat (255) @(posedge clk);
    do_ack();                    // ack on the timeout cycle
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({obs[9:6], bus.op_count} !== {4'b0010, exp_cnt}) begin
      failures++; $display("FAIL tmo_ack: got %h expected %h", {obs[9:6], bus.op_count}, {4'b0010, exp_cnt});
    end
  endtask
`else
  task automatic test_no_timeout();
    run_op(4'd1, 4'd2, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (obs !== {2'b11, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0}) begin
      failures++; $display("FAIL show_wait: got %h expected %h", obs, {2'b11, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0});
    end
    do_ack();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({obs[9:6], bus.op_count} !== {4'b0010, exp_cnt}) begin
      failures++; $display("FAIL show_wait_ack: got %h expected %h", {obs[9:6], bus.op_count}, {4'b0010, exp_cnt});
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst            = 1'b1;
    bus.clear      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.sw         = 4'h0;
    bus.op_sub     = 1'b0;
    bus.result_ack = 1'b0;
    exp_cnt        = 8'd0;

    test_reset();
    test_add();
    test_add_carry();
    test_sub();
    test_ignore();
    test_clear();
    test_reset_mid();
    test_wrap();
`ifdef CALC_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high: clk, rst.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous abort to operand-A entry
- in_valid  input  1  operand on sw is valid
- sw  input  4  operand value
- op_sub  input  1  1 = subtract, 0 = add; sampled with operand B
- in_ready  output  1  block accepts an operand this cycle
- result_ack  input  1  consumer has taken the result
- result_valid  output  1  result/flag outputs are valid
- result  output  4  sum, or difference magnitude
- neg  output  1  subtract: B > A
- carry  output  1  add: A + B > 15
- state_o  output  2  current state encoding
- op_count  output  8  completed operations

Function
REQ-003 The FSM SHALL have four states with these encodings: LOAD_A=2'b00, LOAD_B=2'b01, EXEC=2'b10, SHOW=2'b11; state_o SHALL equal the current state.
REQ-004 in_ready SHALL be 1 only in LOAD_A and LOAD_B; a transfer occurs on in_valid & in_ready.
REQ-005 In LOAD_A, a transfer SHALL store sw into register A and move to LOAD_B.
REQ-006 In LOAD_B, a transfer SHALL store sw into B, latch op_sub, and move to EXEC.
REQ-007 In EXEC, add SHALL produce result=(A+B)[3:0], carry=(A+B)[4], neg=0.
REQ-008 In EXEC, subtract SHALL produce result=|A-B| as an unsigned 4-bit magnitude, neg=(B>A), carry=0.
REQ-009 A=B under subtract SHALL give result=0 and neg=0.
REQ-010 EXEC SHALL register result, neg and carry, and SHALL move to SHOW after exactly one cycle.
REQ-011 result_valid SHALL be 1 exactly when in SHOW; with B transferred at edge N, result_valid SHALL rise after edge N+1.
REQ-012 result, neg and carry SHALL hold stable throughout SHOW.
REQ-013 In SHOW, result_ack=1 SHALL move to LOAD_A and increment op_count, which wraps 255->0.
REQ-014 result_ack outside SHOW SHALL be ignored; in_valid outside LOAD_A/LOAD_B SHALL be ignored and no register SHALL change.
REQ-015 clear=1 in any state SHALL move to LOAD_A on the next edge and zero A, B, result, neg and carry; op_count SHALL be unchanged.
REQ-016 clear and result_ack asserted together in SHOW: clear SHALL win and op_count SHALL NOT increment.
REQ-017 clear and a transfer in the same cycle: the transfer SHALL be discarded.

Reset
REQ-018 rst SHALL take priority over every other input.
REQ-019 rst SHALL set state=LOAD_A, A=B=0, the latched op to add, result=0, neg=0, carry=0, op_count=0.
REQ-020 Out of reset, in_ready=1 and result_valid=0 from the first cycle.
REQ-021 rst asserted in EXEC or SHOW SHALL discard the operation with no op_count increment.

Configuration
REQ-022 When CALC_SEQ_TIMEOUT_EN is defined, an 8-bit counter SHALL clear on entry to SHOW and increment each SHOW cycle.
REQ-023 With the macro defined and the counter at 255 without result_ack, the FSM SHALL return to LOAD_A without incrementing op_count.
REQ-024 A result_ack arriving on the timeout cycle SHALL take priority, and op_count SHALL increment.
REQ-025 With the macro undefined, SHOW SHALL wait indefinitely for result_ack and no timeout counter SHALL exist.

Verification
REQ-026 Reset, then transfer A=5, B=3 (add) -> SHOW after 2 cycles, result=8, carry=0, neg=0.
REQ-027 A=9, B=9 (add) -> result=2, carry=1; result_ack -> LOAD_A, op_count=1.
REQ-028 A=3, B=7 (sub) -> result=4, neg=1; A=7, B=7 (sub) -> result=0, neg=0.
REQ-029 clear in LOAD_B, and clear+result_ack together in SHOW -> LOAD_A next cycle, outputs zeroed, op_count unchanged; in_valid during EXEC/SHOW is ignored.
REQ-030 256 acked operations -> op_count wraps to 0.
REQ-031 With CALC_SEQ_TIMEOUT_EN, holding SHOW with no ack -> LOAD_A after 256 SHOW cycles, op_count unchanged; with ack on the timeout cycle -> op_count increments.
